// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared types and constants for the counter load scheduler.
//   sched_state_t : scheduler FSM encoding (IDLE, LOAD, GAP)
//   DATA_W_DEF    : default counter / load-data width
//   GAP_W         : width of the free-run gap counter (covers HOLD_CYCLES 0..15)
package ctr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int GAP_W      = 4;

endpackage

// File: rtl/ctr_rr_pick.sv
// ctr_rr_pick: combinational round-robin selector.
//   req_valid  in  NUM_REQ  requests
//   last_grant in  IDX_W    most recently served index; search starts one above it
//   grant      out NUM_REQ  one-hot winner (zero when nothing is valid)
//   idx        out IDX_W    binary index of the winner
//   any_valid  out 1        at least one request present
module ctr_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  always_comb begin
    int   j;
    logic found;
    grant     = '0;
    idx       = '0;
    found     = 1'b0;
    j         = 0;
    any_valid = |req_valid;
    // Walk last_grant+1 .. last_grant+NUM_REQ so the previous winner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ctr_load_sched.sv
// ctr_load_sched: round-robin owner of a free-running counter's load port.
// One request is accepted per valid/ready handshake in IDLE; the captured
// value is presented with a one-cycle load strobe (LOAD), then the counter
// is left to free-run for HOLD_CYCLES cycles (GAP) before the next grant.
//   clk, reset_l            clock, async active-low reset
//   req_valid/req_data      per-requester request and load value (slice i*DATA_W)
//   req_ready               combinational accept, at most one bit
//   ctr_load/ctr_in_data    registered load strobe and value to the counter
//   ctr_out_data            counter value (used only for auto-reload)
//   busy                    registered, high in LOAD or GAP
//   last_grant              registered index of most recent accepted requester
// Optional: CTR_LOAD_SCHED_AUTORELOAD_EN adds reload_en/reload_value; an idle
// scheduler seeing the counter at all-ones-minus-one loads reload_value so the
// counter skips the wrap to zero.
module ctr_load_sched
  import ctr_sched_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  HOLD_CYCLES = 2,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctr_load,
  output logic [DATA_W-1:0]         ctr_in_data,
  input  logic [DATA_W-1:0]         ctr_out_data,
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
  input  logic                      reload_en,
  input  logic [DATA_W-1:0]         reload_value,
`endif
  output logic                      busy,
  output logic [IDX_W-1:0]          last_grant
);

  sched_state_t      state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              ctr_load_q, ctr_load_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  lg_q, lg_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   idx;
  logic               any_valid;
  logic               hs;
  logic               reload_hit;

  ctr_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (req_valid),
    .last_grant(lg_q),
    .grant     (grant),
    .idx       (idx),
    .any_valid (any_valid)
  );

  assign hs = (state_q == IDLE) && any_valid;

`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
  // Requests win; reload only fires when idle and nobody is asking.
  assign reload_hit = (state_q == IDLE) && !any_valid && reload_en &&
                      (ctr_out_data == {{(DATA_W-1){1'b1}}, 1'b0});
`else
  logic unused_ctr_out;
  assign unused_ctr_out = ^ctr_out_data;
  assign reload_hit     = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      ctr_load_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      lg_q       <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      ctr_load_q <= ctr_load_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      lg_q       <= lg_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: if (hs || reload_hit) state_d = LOAD;
      LOAD: begin
        if (HOLD_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GAP_W'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; strobe and busy are registered from the next state so they line
  // up with LOAD/GAP without decode glitches.
  always_comb begin
    req_ready  = (state_q == IDLE && reset_l) ? grant : '0;
    ctr_load_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    data_d     = data_q;
    lg_d       = lg_q;
    if (hs) begin
      data_d = req_data[idx*DATA_W +: DATA_W];
      lg_d   = idx;
    end
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
    else if (reload_hit) begin
      data_d = reload_value;
    end
`endif
  end

  assign ctr_load    = ctr_load_q;
  assign ctr_in_data = data_q;
  assign busy        = busy_q;
  assign last_grant  = lg_q;

endmodule

// File: tb/tb_ctr_load_sched.sv
// tb_ctr_load_sched: directed bench for ctr_load_sched. Two instances share
// clock and reset: dut0 (HOLD_CYCLES=2) and dut1 (HOLD_CYCLES=0). Each drives
// a bench-side 8-bit loadable free-running counter. Auto-reload checks are
// included when CTR_LOAD_SCHED_AUTORELOAD_EN is defined.
module tb_ctr_load_sched;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  logic [NR-1:0]    rv0, rr0, rv1, rr1;
  logic [NR*DW-1:0] rd0, rd1;
  logic             ld0, ld1, busy0, busy1;
  logic [DW-1:0]    cid0, cid1, cnt0, cnt1;
  logic [1:0]       lg0, lg1;
  int vecs = 0;
  int errs = 0;
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
  logic          re0 = 1'b0;
  logic [DW-1:0] rvl0 = '0;
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= ld0 ? cid0 : cnt0 + 8'd1;
      cnt1 <= ld1 ? cid1 : cnt1 + 8'd1;
    end
  end

  ctr_load_sched #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(2)) dut0 (
    .clk(clk), .reset_l(reset_l), .req_valid(rv0), .req_data(rd0),
    .req_ready(rr0), .ctr_load(ld0), .ctr_in_data(cid0), .ctr_out_data(cnt0),
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
    .reload_en(re0), .reload_value(rvl0),
`endif
    .busy(busy0), .last_grant(lg0)
  );

  ctr_load_sched #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(0)) dut1 (
    .clk(clk), .reset_l(reset_l), .req_valid(rv1), .req_data(rd1),
    .req_ready(rr1), .ctr_load(ld1), .ctr_in_data(cid1), .ctr_out_data(cnt1),
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
    .reload_en(1'b0), .reload_value(8'h00),
`endif
    .busy(busy1), .last_grant(lg1)
  );

  task automatic test_reset();
    reset_l = 1'b0; rv0 = '1; rd0 = '1; rv1 = '1; rd1 = '1;
    #12;
    vecs++; if (rr0 !== 4'b0000) begin errs++; $display("FAIL rst_ready0: got %b exp 0000", rr0); end
    vecs++; if (rr1 !== 4'b0000) begin errs++; $display("FAIL rst_ready1: got %b exp 0000", rr1); end
    vecs++; if (ld0 !== 1'b0) begin errs++; $display("FAIL rst_load: got %b exp 0", ld0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b exp 0", busy0); end
    vecs++; if (cid0 !== 8'h00) begin errs++; $display("FAIL rst_data: got %h exp 00", cid0); end
    vecs++; if (lg0 !== 2'd3) begin errs++; $display("FAIL rst_last_grant: got %0d exp 3", lg0); end
    rv0 = '0; rv1 = '0; rd0 = '0; rd1 = '0;
    @(negedge clk) reset_l = 1'b1;
    @(negedge clk);
    vecs++; if (busy0 !== 1'b0 || rr0 !== 4'b0000) begin errs++; $display("FAIL idle_after_rst: busy %b ready %b exp 0 0000", busy0, rr0); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    @(posedge clk); #1 rd0[16 +: 8] = 8'h5A; rv0 = 4'b0100;
    @(negedge clk);
    vecs++; if (rr0 !== 4'b0100) begin errs++; $display("FAIL single_ready: got %b exp 0100", rr0); end
    @(posedge clk); #1 rd0[16 +: 8] = 8'h33;
    @(negedge clk);
    vecs++; if (ld0 !== 1'b1 || cid0 !== 8'h5A) begin errs++; $display("FAIL single_load: got %b/%h exp 1/5a", ld0, cid0); end
    vecs++; if (busy0 !== 1'b1 || lg0 !== 2'd2 || rr0 !== 4'b0000) begin errs++; $display("FAIL single_state: busy %b lg %0d ready %b exp 1 2 0000", busy0, lg0, rr0); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      e = 8'h5A + 8'(k - 2);
      vecs++; if (cnt0 !== e) begin errs++; $display("FAIL single_cnt T+%0d: got %h exp %h", k, cnt0, e); end
      vecs++;
      if (k < 4 && rr0 !== 4'b0000) begin errs++; $display("FAIL single_gap_ready T+%0d: got %b exp 0000", k, rr0); end
      else if (k == 4 && (rr0 !== 4'b0100 || busy0 !== 1'b0)) begin errs++; $display("FAIL single_regrant: ready %b busy %b exp 0100 0", rr0, busy0); end
    end
    @(posedge clk); #1 rv0 = '0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_rr();
    logic [7:0] dv [4];
    int g;
    dv = '{8'h10, 8'h20, 8'h30, 8'h40};
    @(negedge clk) reset_l = 1'b0;
    @(negedge clk) reset_l = 1'b1;
    rd0 = {8'h40, 8'h30, 8'h20, 8'h10};
    @(posedge clk); #1 rv0 = 4'hF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      g = (k / 4) % 4;
      vecs++; if ($countones(rr0) > 1) begin errs++; $display("FAIL rr_onehot c%0d: got %b", k, rr0); end
      if (k % 4 == 0) begin
        vecs++; if (rr0 !== 4'(1 << g)) begin errs++; $display("FAIL rr_grant c%0d: got %b exp %b", k, rr0, 4'(1 << g)); end
      end else if (k % 4 == 1) begin
        vecs++; if (lg0 !== 2'(g) || cid0 !== dv[g] || ld0 !== 1'b1) begin errs++; $display("FAIL rr_load c%0d: lg %0d data %h ld %b exp %0d %h 1", k, lg0, cid0, ld0, g, dv[g]); end
      end else begin
        vecs++; if (rr0 !== 4'b0000) begin errs++; $display("FAIL rr_gap c%0d: got %b exp 0000", k, rr0); end
      end
    end
    @(posedge clk); #1 rv0 = '0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 rd1[8 +: 8] = 8'h11; rv1 = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        vecs++; if (rr1 !== 4'b0010 || ld1 !== 1'b0) begin errs++; $display("FAIL b2b_grant c%0d: ready %b ld %b exp 0010 0", k, rr1, ld1); end
        if (k >= 2) begin
          vecs++; if (cnt1 !== 8'h11) begin errs++; $display("FAIL b2b_cnt c%0d: got %h exp 11", k, cnt1); end
        end
      end else begin
        vecs++; if (rr1 !== 4'b0000 || ld1 !== 1'b1 || cid1 !== 8'h11) begin errs++; $display("FAIL b2b_load c%0d: ready %b ld %b data %h exp 0000 1 11", k, rr1, ld1, cid1); end
      end
    end
    @(posedge clk); #1 rv1 = '0;
    @(negedge clk);
    vecs++; if (lg1 !== 2'd1) begin errs++; $display("FAIL b2b_last_grant: got %0d exp 1", lg1); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1 rd0[24 +: 8] = 8'h40; rd0[0 +: 8] = 8'h01; rv0 = 4'b1000;
    @(negedge clk);
    vecs++; if (rr0 !== 4'b1000) begin errs++; $display("FAIL ar_grant3: got %b exp 1000", rr0); end
    @(posedge clk); #1 rv0 = 4'b1001;
    @(negedge clk);
    vecs++; if (ld0 !== 1'b1) begin errs++; $display("FAIL ar_in_load: got %b exp 1", ld0); end
    #1 reset_l = 1'b0;
    #1;
    vecs++; if (ld0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL ar_clear: ld %b busy %b exp 0 0", ld0, busy0); end
    vecs++; if (lg0 !== 2'd3 || cid0 !== 8'h00 || rr0 !== 4'b0000) begin errs++; $display("FAIL ar_regs: lg %0d data %h ready %b exp 3 00 0000", lg0, cid0, rr0); end
    #1 reset_l = 1'b1;
    #1;
    vecs++; if (rr0 !== 4'b0001) begin errs++; $display("FAIL ar_prio0: got %b exp 0001", rr0); end
    @(posedge clk); #1 rv0 = '0;
    @(negedge clk);
    vecs++; if (lg0 !== 2'd0 || ld0 !== 1'b1 || cid0 !== 8'h01) begin errs++; $display("FAIL ar_post_load: lg %0d ld %b data %h exp 0 1 01", lg0, ld0, cid0); end
    repeat (4) @(posedge clk);
  endtask

`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
  task automatic test_autoreload();
    logic found;
    @(posedge clk); #1 rd0[0 +: 8] = 8'hF8; rv0 = 4'b0001; re0 = 1'b1; rvl0 = 8'h80;
    @(posedge clk); #1 rv0 = '0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (cnt0 == 8'hFE) found = 1'b1;
    end
    vecs++; if (!found) begin errs++; $display("FAIL autoreload_fe_timeout: got no FE exp FE"); end
    vecs++; if (rr0 !== 4'b0000) begin errs++; $display("FAIL autoreload_ready: got %b exp 0000", rr0); end
    @(negedge clk);
    vecs++; if (cnt0 !== 8'hFF || ld0 !== 1'b1 || cid0 !== 8'h80) begin errs++; $display("FAIL autoreload_load: cnt %h ld %b data %h exp ff 1 80", cnt0, ld0, cid0); end
    @(negedge clk);
    vecs++; if (cnt0 !== 8'h80) begin errs++; $display("FAIL autoreload_80: got %h exp 80", cnt0); end
    @(negedge clk);
    vecs++; if (cnt0 !== 8'h81 || lg0 !== 2'd0) begin errs++; $display("FAIL autoreload_81: cnt %h lg %0d exp 81 0", cnt0, lg0); end
    re0 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_req_beats_reload();
    logic found;
    @(posedge clk); #1 rd0[0 +: 8] = 8'hF8; rv0 = 4'b0001; re0 = 1'b1;
    @(posedge clk); #1 rv0 = '0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (cnt0 == 8'hFD) found = 1'b1;
    end
    vecs++; if (!found) begin errs++; $display("FAIL rw_fd_timeout: got no FD exp FD"); end
    @(posedge clk); #1 rd0[0 +: 8] = 8'h07; rv0 = 4'b0001;
    @(negedge clk);
    vecs++; if (cnt0 !== 8'hFE || rr0 !== 4'b0001) begin errs++; $display("FAIL rw_grant: cnt %h ready %b exp fe 0001", cnt0, rr0); end
    @(posedge clk); #1 rv0 = '0;
    @(negedge clk);
    vecs++; if (ld0 !== 1'b1 || cid0 !== 8'h07) begin errs++; $display("FAIL rw_load: ld %b data %h exp 1 07", ld0, cid0); end
    @(negedge clk);
    vecs++; if (cnt0 !== 8'h07) begin errs++; $display("FAIL rw_cnt07: got %h exp 07", cnt0); end
    @(negedge clk);
    vecs++; if (cnt0 !== 8'h08) begin errs++; $display("FAIL rw_cnt08: got %h exp 08", cnt0); end
    re0 = 1'b0;
    repeat (4) @(posedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_back_to_back();
    test_async_reset();
`ifdef CTR_LOAD_SCHED_AUTORELOAD_EN
    test_autoreload();
    test_req_beats_reload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
